// File: rtl/aes_pkg.sv
// Shared AES constants, round-index width helper and the key-pipe FSM state type.
package aes_pkg;

    localparam int AES_WORD_W = 32;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_ZERO = 1'b1
    } ark_state_e;

    function automatic int round_idx_w(input int num_rounds);
        return $clog2(num_rounds + 1);
    endfunction

endpackage

// File: rtl/ark_key_store.sv
// Round-key store: one key and one loaded flag per round, synchronous write and
// clear ports, combinational read port that reports whether the entry is usable.
module ark_key_store
    import aes_pkg::*;
#(
    parameter  int NUM_WORDS  = 4,
    parameter  int NUM_ROUNDS = 10,
    localparam int RW         = round_idx_w(NUM_ROUNDS),
    localparam int KW         = AES_WORD_W * NUM_WORDS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [RW-1:0] waddr_i,
    input  logic [KW-1:0] wdata_i,
    input  logic          clr_i,
    input  logic [RW-1:0] caddr_i,
    input  logic [RW-1:0] raddr_i,
    output logic [KW-1:0] rdata_o,
    output logic          rloaded_o
);

    logic [KW-1:0]       key_q [NUM_ROUNDS+1];
    logic [NUM_ROUNDS:0] loaded_q;
    logic                wr_ok;
    logic                rd_ok;

    assign wr_ok = we_i && (waddr_i <= RW'(NUM_ROUNDS));
    assign rd_ok = raddr_i <= RW'(NUM_ROUNDS);

    // NOTE: key words carry no reset; loaded_q alone decides whether a key may be used.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            key_q[caddr_i] <= '0;
        end else if (wr_ok) begin
            key_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded_q <= '0;
        end else if (clr_i) begin
            loaded_q[caddr_i] <= 1'b0;
        end else if (wr_ok) begin
            loaded_q[waddr_i] <= 1'b1;
        end
    end

    assign rdata_o   = rd_ok ? key_q[raddr_i] : '0;
    assign rloaded_o = rd_ok && loaded_q[raddr_i];

endmodule

// File: rtl/add_round_key_pipe.sv
// One-cycle AES AddRoundKey stage with a valid/ready output register and a round-key store.
// Define ARK_ZEROIZE_EN to add the zeroize port and the ZERO key-clearing state.
module add_round_key_pipe
    import aes_pkg::*;
#(
    parameter  int NUM_WORDS  = 4,
    parameter  int NUM_ROUNDS = 10,
    localparam int RW         = round_idx_w(NUM_ROUNDS),
    localparam int DW         = AES_WORD_W * NUM_WORDS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_we,
    input  logic [RW-1:0] key_addr,
    input  logic [DW-1:0] key_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [RW-1:0] in_round,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [RW-1:0] out_round,
    output logic          out_err
`ifdef ARK_ZEROIZE_EN
    ,
    input  logic          zeroize
`endif
);

    ark_state_e    state_q;
    logic [RW-1:0] zcnt_q;
    logic          clr;
    logic          accept;
    logic [DW-1:0] key_rd;
    logic          key_ok;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic [RW-1:0] out_round_q, out_round_d;
    logic          out_err_q,   out_err_d;

`ifdef ARK_ZEROIZE_EN
    // ZERO walks zcnt_q over every entry, clearing one per cycle, then returns to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            zcnt_q  <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (zeroize) begin
                        state_q <= ST_ZERO;
                        zcnt_q  <= '0;
                    end
                end
                ST_ZERO: begin
                    if (zcnt_q == RW'(NUM_ROUNDS)) begin
                        state_q <= ST_RUN;
                        zcnt_q  <= '0;
                    end else begin
                        zcnt_q <= zcnt_q + RW'(1);
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end
    assign clr = (state_q == ST_ZERO);
`else
    assign state_q = ST_RUN;
    assign zcnt_q  = '0;
    assign clr     = 1'b0;
`endif

    ark_key_store #(
        .NUM_WORDS (NUM_WORDS),
        .NUM_ROUNDS(NUM_ROUNDS)
    ) u_key_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (key_we && (state_q == ST_RUN)),
        .waddr_i  (key_addr),
        .wdata_i  (key_data),
        .clr_i    (clr),
        .caddr_i  (zcnt_q),
        .raddr_i  (in_round),
        .rdata_o  (key_rd),
        .rloaded_o(key_ok)
    );

    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_round_d = out_round_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_round_d = in_round;
            out_err_d   = !key_ok;
            out_data_d  = key_ok ? (in_data ^ key_rd) : in_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_round_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_round_q <= out_round_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_round = out_round_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_add_round_key_pipe.sv
// Self-checking bench for add_round_key_pipe: a queue-based model checked every cycle
// plus directed vectors with hand-computed literal results.
`timescale 1ns/1ps
module tb_add_round_key_pipe;
    import aes_pkg::*;

    localparam int NW = 4;
    localparam int NR = 10;
    localparam int RW = round_idx_w(NR);
    localparam int DW = 32 * NW;

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] round;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_we = 1'b0;
    logic [RW-1:0] key_addr = '0;
    logic [DW-1:0] key_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [RW-1:0] in_round = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_round;
    logic          out_err;
`ifdef ARK_ZEROIZE_EN
    logic          zeroize = 1'b0;
`endif

    always #5 clk = ~clk;

    add_round_key_pipe #(.NUM_WORDS(NW), .NUM_ROUNDS(NR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_we   (key_we),
        .key_addr (key_addr),
        .key_data (key_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_round (in_round),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_round(out_round),
        .out_err  (out_err)
`ifdef ARK_ZEROIZE_EN
        ,
        .zeroize  (zeroize)
`endif
    );

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_popped = 0;
    exp_t          q[$];
    logic [DW-1:0] key_m [16];
    bit            loaded_m [16];
    int            zero_left = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [DW-1:0] d, input logic [RW-1:0] r);
        exp_t e;
        e.round = r;
        e.data  = d;
        e.err   = 1'b1;
        if (int'(r) <= NR && loaded_m[r]) begin
            e.err = 1'b0;
            for (int w = 0; w < NW; w++) e.data[32*w +: 32] = d[32*w +: 32] ^ key_m[r][32*w +: 32];
        end
        return e;
    endfunction

    // Inputs change just after posedge, so at negedge they show what the next edge will see.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            foreach (loaded_m[i]) loaded_m[i] = 1'b0;
            zero_left = 0;
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_out_round", out_round, 0);
            check("rst_out_err", out_err, 0);
        end else begin
            bit exp_rdy;
            exp_rdy = (zero_left == 0) && (q.size() == 0 || out_ready);
            check("in_ready", in_ready, exp_rdy);
            check("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0 && out_valid) begin
                check("out_data", out_data, q[0].data);
                check("out_round", out_round, q[0].round);
                check("out_err", out_err, q[0].err);
            end
            if (q.size() != 0 && out_ready) begin
                void'(q.pop_front());
                n_popped++;
            end
            if (in_valid && exp_rdy) q.push_back(model(in_data, in_round));
            if (zero_left > 0) begin
                zero_left--;
            end else begin
                if (key_we && int'(key_addr) <= NR) begin
                    key_m[key_addr]    = key_data;
                    loaded_m[key_addr] = 1'b1;
                end
`ifdef ARK_ZEROIZE_EN
                if (zeroize) begin
                    zero_left = NR + 1;
                    foreach (loaded_m[i]) loaded_m[i] = 1'b0;
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key_write(input int a, input logic [DW-1:0] d);
        key_we   = 1'b1;
        key_addr = RW'(a);
        key_data = d;
        tick();
        key_we   = 1'b0;
    endtask

    // Returns at posedge+1 after the edge that accepted the block.
    task automatic send(input logic [DW-1:0] d, input logic [RW-1:0] r);
        bit acc;
        int n;
        n        = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_round = r;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: block round %0d not accepted within %0d cycles", r, n);
        end
    endtask

    function automatic logic [DW-1:0] kgen(input int i);
        logic [DW-1:0] k;
        k = {NW{32'h9e3779b9 * 32'(i + 1)}};
        k[31:0] = k[31:0] ^ 32'(i);
        return k;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] blk;
        int            base;
        int            n;
        int            cnt;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        tick();

        // Reference vector: round 0 key 00..0f.
        key_write(0, 128'h000102030405060708090a0b0c0d0e0f);
        send(128'h00112233445566778899aabbccddeeff, 0);
        in_valid = 1'b0;
        check("vec_valid", out_valid, 1);
        check("vec_data", out_data, 128'h00102030405060708090a0b0c0d0e0f0);
        check("vec_err", out_err, 0);

        // Unloaded entry and out-of-range round both pass through unkeyed.
        send(128'h0123456789abcdef0123456789abcdef, 5);
        in_valid = 1'b0;
        check("unloaded_err", out_err, 1);
        check("unloaded_data", out_data, 128'h0123456789abcdef0123456789abcdef);
        send(128'hfedcba9876543210fedcba9876543210, 11);
        in_valid = 1'b0;
        check("range_err", out_err, 1);
        check("range_data", out_data, 128'hfedcba9876543210fedcba9876543210);

        // Key write coinciding with acceptance must not touch that block.
        key_write(3, '0);
        key_we   = 1'b1;
        key_addr = 3;
        key_data = '1;
        send(128'h5a5a5a5a00000000ffffffff12345678, 3);
        key_we   = 1'b0;
        in_valid = 1'b0;
        check("wr_same_cycle_data", out_data, 128'h5a5a5a5a00000000ffffffff12345678);
        check("wr_same_cycle_err", out_err, 0);
        send(128'h5a5a5a5a00000000ffffffff12345678, 3);
        in_valid = 1'b0;
        check("wr_next_data", out_data, 128'ha5a5a5a5ffffffff00000000edcba987);

        // Full stream with a three-cycle downstream stall.
        for (int i = 0; i <= NR; i++) key_write(i, kgen(i));
        base = n_popped;
        fork
            begin
                for (int r = 0; r <= NR; r++) begin
                    blk = {NW{32'h11111111 * 32'(r)}} ^ 128'hcafef00d_00c0ffee_deadbeef_0badf00d;
                    send(blk, RW'(r));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #2 out_ready = 1'b0;
                #1 check("stall_in_ready", in_ready, 0);
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        n = 0;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("stream_count", n_popped - base, NR + 1);

`ifdef ARK_ZEROIZE_EN
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        cnt = 0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (in_ready) break;
            cnt++;
            n++;
        end
        check("zero_cycles", cnt, NR + 1);
        tick();
        send(128'h0f0e0d0c0b0a09080706050403020100, 0);
        in_valid = 1'b0;
        check("zero_after_err", out_err, 1);
        check("zero_after_data", out_data, 128'h0f0e0d0c0b0a09080706050403020100);
        for (int i = 0; i <= NR; i++) key_write(i, kgen(i));
`endif

        // Reset while a block is held under backpressure.
        out_ready = 1'b0;
        send(128'h13579bdf2468ace013579bdf2468ace0, 0);
        in_valid = 1'b0;
        tick();
        check("held_valid", out_valid, 1);
        rst_n = 1'b0;
        #1 check("rst_drop_valid", out_valid, 0);
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(128'h13579bdf2468ace013579bdf2468ace0, 0);
        in_valid = 1'b0;
        check("post_rst_err0", out_err, 1);
        check("post_rst_data0", out_data, 128'h13579bdf2468ace013579bdf2468ace0);
        send(128'h00000000000000000000000000000001, 7);
        in_valid = 1'b0;
        check("post_rst_err7", out_err, 1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
